// File: rtl/fractal_sync_dm_rf_if.sv
// Child/parent handshake bundle for one fractal-sync tree node.
// Slave is the barrier node; master drives children and the parent side.
interface fractal_sync_dm_rf_if #(
  parameter int N_PORTS = 2,
  parameter int ID_W    = 4,
  parameter int LVL_W   = 4
) ();
  logic [N_PORTS-1:0]            req_valid_i;
  logic [N_PORTS-1:0][ID_W-1:0]  req_id_i;
  logic [N_PORTS-1:0][LVL_W-1:0] req_lvl_i;
  logic                          req_ready_o;
  logic [N_PORTS-1:0]            rsp_valid_o;
  logic [ID_W-1:0]               rsp_id_o;
  logic [N_PORTS-1:0]            err_o;
  logic                          up_valid_o;
  logic [ID_W-1:0]               up_id_o;
  logic [LVL_W-1:0]              up_lvl_o;
  logic                          up_ready_i;
  logic                          up_rsp_valid_i;
  logic [ID_W-1:0]               up_rsp_id_i;

  modport slave (
    input  req_valid_i,
    input  req_id_i,
    input  req_lvl_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_id_o,
    output err_o,
    output up_valid_o,
    output up_id_o,
    output up_lvl_o,
    input  up_ready_i,
    input  up_rsp_valid_i,
    input  up_rsp_id_i
  );

  modport master (
    output req_valid_i,
    output req_id_i,
    output req_lvl_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_id_o,
    input  err_o,
    input  up_valid_o,
    input  up_id_o,
    input  up_lvl_o,
    output up_ready_i,
    output up_rsp_valid_i,
    output up_rsp_id_i
  );
endinterface

// File: rtl/fractal_sync_dm_rf.sv
// Direct-mapped barrier register file for one fractal-sync tree node.
// Merges child arrivals per ID; wakes children locally or goes upward.
module fractal_sync_dm_rf #(
  parameter int N_PORTS  = 2,
  parameter int ID_W     = 4,
  parameter int LVL_W    = 4,
  parameter int NODE_LVL = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fractal_sync_dm_rf_if.slave  bus
);
  localparam int NE = 1 << ID_W;
  localparam logic [LVL_W-1:0] NLVL = LVL_W'(NODE_LVL);
  localparam logic [N_PORTS-1:0] ALL1 = '1;

  logic [NE-1:0][N_PORTS-1:0] r_arr;
  logic [NE-1:0][LVL_W-1:0]   r_lvl;
  logic [N_PORTS-1:0]         r_rsp_valid;
  logic [ID_W-1:0]            r_rsp_id;
  logic [N_PORTS-1:0]         r_err;
  logic                       r_up_valid;
  logic [ID_W-1:0]            r_up_id;
  logic [LVL_W-1:0]           r_up_lvl;
  logic                       r_pend;
  logic [ID_W-1:0]            r_pend_id;

  logic                       w_ready;
  logic [N_PORTS-1:0]         w_acc;
  logic [N_PORTS-1:0]         w_bad;
  logic [N_PORTS-1:0]         w_legal;
  logic [NE-1:0][N_PORTS-1:0] w_next;
  logic [NE-1:0][LVL_W-1:0]   w_nlvl;
  logic [NE-1:0]              w_touch;
  logic [NE-1:0]              w_full;
  logic                       w_new_hit;
  logic [ID_W-1:0]            w_new_id;
  logic                       w_scan_hit;
  logic [ID_W-1:0]            w_scan_id;
  logic                       w_comp;
  logic [ID_W-1:0]            w_cid;
  logic [LVL_W-1:0]           w_clvl;
  logic                       w_loc;
  logic                       w_upc;

  assign w_ready = !(r_up_valid && !bus.up_ready_i)
                && !r_pend;

  assign bus.req_ready_o = w_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_id_o    = r_rsp_id;
  assign bus.err_o       = r_err;
  assign bus.up_valid_o  = r_up_valid;
  assign bus.up_id_o     = r_up_id;
  assign bus.up_lvl_o    = r_up_lvl;

  always_comb begin
    w_acc   = '0;
    w_bad   = '0;
    w_legal = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_acc[p] = bus.req_valid_i[p] && w_ready;
      w_bad[p] = w_acc[p]
        && ((bus.req_lvl_i[p] < NLVL)
         || r_arr[bus.req_id_i[p]][p]);
      w_legal[p] = w_acc[p] && !w_bad[p];
    end
  end

  // Entries keep the highest level seen so far.
  always_comb begin
    w_next  = r_arr;
    w_nlvl  = r_lvl;
    w_touch = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_legal[p]) begin
        w_next[bus.req_id_i[p]][p] = 1'b1;
        w_touch[bus.req_id_i[p]]   = 1'b1;
        if (bus.req_lvl_i[p] > w_nlvl[bus.req_id_i[p]])
          w_nlvl[bus.req_id_i[p]] = bus.req_lvl_i[p];
      end
    end
    for (int e = 0; e < NE; e++)
      w_full[e] = &w_next[e];
  end

  // Lowest ID wins; untouched full entries are the rescan pool.
  always_comb begin
    w_new_hit  = 1'b0;
    w_new_id   = '0;
    w_scan_hit = 1'b0;
    w_scan_id  = '0;
    for (int e = NE - 1; e >= 0; e--) begin
      if (w_full[e] && w_touch[e]) begin
        w_new_hit = 1'b1;
        w_new_id  = ID_W'(e);
      end
      if (w_full[e]) begin
        w_scan_hit = 1'b1;
        w_scan_id  = ID_W'(e);
      end
    end
  end

  assign w_comp = w_ready && (w_new_hit || w_scan_hit);
  assign w_cid  = w_new_hit ? w_new_id : w_scan_id;
  assign w_clvl = w_nlvl[w_cid];
  assign w_loc  = w_comp && (w_clvl == NLVL);
  assign w_upc  = w_comp && (w_clvl > NLVL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_arr       <= '0;
      r_lvl       <= '0;
      r_rsp_valid <= '0;
      r_rsp_id    <= '0;
      r_err       <= '0;
      r_up_valid  <= 1'b0;
      r_up_id     <= '0;
      r_up_lvl    <= '0;
      r_pend      <= 1'b0;
      r_pend_id   <= '0;
    end else begin
      r_arr <= w_next;
      r_lvl <= w_nlvl;
      if (w_comp) begin
        r_arr[w_cid] <= '0;
        r_lvl[w_cid] <= '0;
      end
      r_err       <= w_bad;
      r_rsp_valid <= '0;
      // Parent wake has priority; a colliding local wake is parked.
      if (bus.up_rsp_valid_i) begin
        r_rsp_valid <= ALL1;
        r_rsp_id    <= bus.up_rsp_id_i;
        if (w_loc) begin
          r_pend    <= 1'b1;
          r_pend_id <= w_cid;
        end
      end else if (r_pend) begin
        r_rsp_valid <= ALL1;
        r_rsp_id    <= r_pend_id;
        r_pend      <= 1'b0;
      end else if (w_loc) begin
        r_rsp_valid <= ALL1;
        r_rsp_id    <= w_cid;
      end
      if (w_upc) begin
        r_up_valid <= 1'b1;
        r_up_id    <= w_cid;
        r_up_lvl   <= w_clvl;
      end else if (bus.up_ready_i) begin
        r_up_valid <= 1'b0;
        r_up_id    <= '0;
        r_up_lvl   <= '0;
      end
    end
  end
endmodule

// File: doc/fractal_sync_dm_rf.md
# fractal_sync_dm_rf

Direct-mapped barrier register file for one fractal-sync tree node, generalising the fixed two-child CAM/DM choice to N_PORTS children and 2^ID_W barrier IDs. It collects child arrivals per barrier ID. When every child has arrived, it either broadcasts a wake response to all children (the barrier targets this node's level) or forwards one aggregated request to the parent (the barrier targets a higher level). It relays parent responses back down to the children.

## Interface
- N_PORTS, 2: number of child request/response channels (H01/H02 or H/V pairs; ≥2)
- ID_W, 4: barrier ID width; the RF holds 2^ID_W entries of N_PORTS arrival bits
- LVL_W, 4: barrier level field width
- NODE_LVL, 1: tree level of this node

- clk_i  in  1  clock; one clock domain
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  N_PORTS  per-child request valid
- req_id_i  in  N_PORTS×ID_W  per-child barrier ID
- req_lvl_i  in  N_PORTS×LVL_W  per-child target level
- req_ready_o  out  1  common ready; it applies to every child
- rsp_valid_o  out  N_PORTS  wake pulse per child
- rsp_id_o  out  ID_W  ID of the wake, shared by all children
- err_o  out  N_PORTS  one-cycle error pulse per child
- up_valid_o  out  1  aggregated request to the parent
- up_id_o  out  ID_W  parent request ID
- up_lvl_o  out  LVL_W  parent request level; equals the child level
- up_ready_i  in  1  parent accepts the request
- up_rsp_valid_i  in  1  parent wake pulse; always accepted, no ready
- up_rsp_id_i  in  ID_W  parent wake ID

## Operation
- RF entry e holds arr[e][N_PORTS-1:0]. Bit p is set when child p has arrived at barrier e.
- Accept condition: req_valid_i[p] && req_ready_o.
- req_ready_o = !(up_valid_o && !up_ready_i) && !pend_q.
- Illegal request, either of:
  - req_lvl_i[p] < NODE_LVL
  - arr[id][p] already set (duplicate arrival)
  - Response: err_o[p] pulses. The request is consumed and the RF is unchanged.
- Same-cycle arrivals from several children are merged.
  - Per ID: next = arr[id] | OR of the legal arrivals at that ID.
  - Distinct IDs update independently in the same cycle.
- Completion: next == all-ones for an ID. That entry is cleared instead of written.
  - Level == NODE_LVL (local barrier): load the response register with rsp_valid = all-ones and rsp_id = id.
  - Level > NODE_LVL (upward barrier): load the up register with up_valid = 1, id and level.
  - If arrivals to one ID carry different levels, the highest level decides the completion type.
  - At most one completion is accepted per cycle. If two IDs complete together, the lowest ID wins. The other IDs' arrivals are still recorded, and their entries stay all-ones minus nothing. Such an entry then completes on its next re-evaluation: the block rescans entries that are all-ones at low priority, one per cycle, when no new completion occurs.
- Parent response: up_rsp_valid_i loads the response register with all-ones and up_rsp_id_i.
  - If it collides with a local completion in the same cycle, the parent response goes out first.
  - The local completion is parked in pend_q/pend_id_q and emitted in the next cycle.
  - req_ready_o is low while pend_q is set.
- Up register:
  - Holds its value while up_valid_o && !up_ready_i.
  - Clears on handshake unless a new upward completion reloads it in the same cycle.

## Timing
- Reset values: rsp_valid_o=0, rsp_id_o=0, err_o=0, up_valid_o=0, up_id_o=0, up_lvl_o=0, req_ready_o=1. All RF entries are 0; pend_q=0.
- Request accepted at edge t: err_o, rsp_valid_o or up_valid_o is visible in cycle t+1 (latency 1).
- rsp_valid_o and err_o are single-cycle pulses. Children must sample them unconditionally.
- Parent wake arriving in cycle t gives rsp_valid_o in cycle t+1. A parked local wake follows in t+2.
- Parent stall: up_valid_o, up_id_o and up_lvl_o stay stable until up_ready_i. Children see req_ready_o=0 for the stall duration.
- Reset asserted mid-barrier clears all partial arrivals, drops any parked or pending request or response, and forces outputs to their reset values asynchronously.
- ID wrap-around: there is none. The ID indexes the RF directly, and all 2^ID_W entries are live at once.

## Test plan
- N_PORTS=2, NODE_LVL=1: child0 sends id 3, lvl 1; child1 sends id 3, lvl 1 two cycles later → one cycle after the second accept, rsp_valid_o=2'b11 and rsp_id_o=3; entry 3 reads 0 afterwards.
- Both children send id 5, lvl 2 in the same cycle, with up_ready_i held low 4 cycles → up_valid_o=1, up_id_o=5, up_lvl_o=2 held stable; req_ready_o=0 for 4 cycles; up_rsp_valid_i with id 5 later → rsp_valid_o=2'b11 and rsp_id_o=5.
- Child0 sends id 7 twice before child1 arrives → second request gives err_o=2'b01; child1 then arrives at id 7 → normal wake for id 7.
- Child1 sends lvl 0 → err_o=2'b10; no RF change.
- Local completion of id 2 in the same cycle as up_rsp_valid_i with id 9 → rsp_id_o=9 in t+1, then rsp_id_o=2 in t+2; req_ready_o=0 in t+1.
- rst_ni pulsed low with child0 arrived at id 4 → child1 arrives at id 4 → no wake; entry 4 holds only child1's bit.
